// File: rtl/fwd_pkg.sv
// Shared constants, FSM encoding and matrix packing helper for forward_sub.
// The packing helper is also used by backward, so both blocks agree on layout.
package fwd_pkg;
    localparam int N     = 4;
    localparam int W     = 32;
    localparam int FRAC  = 14;
    localparam int ACC_W = 2 * W + 3;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Bit offset of element (r,c) in a row-major packed N x N matrix.
    function automatic int unsigned elem_off(input int unsigned r, input int unsigned c);
        return W * (N * r + c);
    endfunction
endpackage

// File: rtl/forward_sub_if.sv
// Request/result bundle for forward_sub. The requester drives start and the
// operands; the solver returns y, busy, the done pulse and the overflow flag.
interface forward_sub_if import fwd_pkg::*; ();
    logic                 start;
    logic [N*N*W-1:0]     L_in;
    logic [N*W-1:0]       b_in;
    logic [N*W-1:0]       y_out;
    logic                 busy;
    logic                 done;
    logic                 ovf;

    modport master (output start, L_in, b_in, input y_out, busy, done, ovf);
    modport slave  (input start, L_in, b_in, output y_out, busy, done, ovf);
endinterface

// File: rtl/fwd_mac.sv
// Combinational multiply-subtract: res = acc - a*b, product kept at full 2W
// bits and sign-extended into the accumulator width.
module fwd_mac import fwd_pkg::*; (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    output logic signed [ACC_W-1:0] res
);
    logic signed [2*W-1:0] prod;

    // Exact signed product, then subtract in the wider accumulator domain.
    always_comb begin
        prod = a * b;
        res  = acc - {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    end
endmodule

// File: rtl/forward_sub.sv
// Sequential 4x4 forward substitution (L*y = b, L unit lower triangular, Q14).
// One multiply-subtract per cycle; start/done handshake through forward_sub_if.
// Optional macro FWD_SAT_EN: saturate y to W bits and raise a sticky ovf flag;
// when undefined, y wraps to W bits and ovf is tied low.
module forward_sub import fwd_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    forward_sub_if.slave io
);
    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       i_q, i_d, j_q, j_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [N*N*W-1:0]       l_q, l_d;
    logic [N*W-1:0]         b_q, b_d;
    logic [N-1:0][W-1:0]    y_q, y_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic signed [ACC_W-1:0] mac_res;
    logic [W-1:0]           store_val;
`ifdef FWD_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
    logic                   ovf_q, ovf_d;
    logic                   store_ovf;
    logic signed [ACC_W-1:0] shifted;
`endif

    // Q14 load of a b element into the accumulator (b <<< FRAC, sign-extended).
    function automatic logic signed [ACC_W-1:0] load_b(input logic [W-1:0] v);
        return {{(ACC_W-W-FRAC){v[W-1]}}, v, {FRAC{1'b0}}};
    endfunction

    fwd_mac u_mac (
        .acc (acc_q),
        .a   (l_q[elem_off(int'(i_q), int'(j_q)) +: W]),
        .b   (y_q[j_q]),
        .res (mac_res)
    );

`ifdef FWD_SAT_EN
    // Floor-shift the accumulator back to Q14 and clamp to the W-bit range.
    always_comb begin
        shifted   = acc_q >>> FRAC;
        store_ovf = 1'b0;
        store_val = shifted[W-1:0];
        if (shifted > SAT_HI) begin
            store_val = SAT_HI[W-1:0];
            store_ovf = 1'b1;
        end else if (shifted < SAT_LO) begin
            store_val = SAT_LO[W-1:0];
            store_ovf = 1'b1;
        end
    end
`else
    // Floor-shift and wrap: the low W bits above the fraction.
    always_comb begin
        store_val = acc_q[FRAC +: W];
    end
`endif

    // Next-state and datapath update for the solve sequence.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        l_d     = l_q;
        b_d     = b_q;
        y_d     = y_q;
        done_d  = 1'b0;
`ifdef FWD_SAT_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    l_d     = io.L_in;
                    b_d     = io.b_in;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = load_b(io.b_in[W-1:0]);
`ifdef FWD_SAT_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = S_STORE;
                end
            end
            S_MAC: begin
                acc_d = mac_res;
                j_d   = j_q + 1'b1;
                // Last column of this row is i-1 (old j).
                if (j_q == i_q - 1'b1)
                    state_d = S_STORE;
            end
            S_STORE: begin
                y_d[i_q] = store_val;
`ifdef FWD_SAT_EN
                ovf_d    = ovf_q | store_ovf;
`endif
                if (i_q == IDX_W'(N-1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    i_d     = i_q + 1'b1;
                    j_d     = '0;
                    acc_d   = load_b(b_q[W*(int'(i_q)+1) +: W]);
                    state_d = S_MAC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // FSM and datapath registers; outputs are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            l_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef FWD_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            l_q     <= l_d;
            b_q     <= b_d;
            y_q     <= y_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef FWD_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign io.y_out = y_q;
    assign io.done  = done_q;
    assign io.busy  = busy_q;
`ifdef FWD_SAT_EN
    assign io.ovf   = ovf_q;
`else
    assign io.ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_forward_sub.sv
// Self-checking bench for forward_sub: directed cases from the block's intent
// plus randomized solves checked against a plain-arithmetic reference solve.
module tb_forward_sub;
    import fwd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    forward_sub_if ifc ();

    forward_sub dut (
        .clk (clk),
        .rst (rst_n),
        .io  (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: y_i = floor((b_i*2^14 - sum_{j<i} L_ij*y_j) / 2^14), fitted to 32 bits.
    function automatic logic [127:0] ref_solve(input logic [511:0] L, input logic [127:0] b,
                                               output logic o);
        logic signed [66:0] acc, q;
        logic signed [31:0] y [4];
        logic [127:0] r;
        o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc = $signed(b[32*i +: 32]);
            acc = acc * 67'sd16384;
            for (int j = 0; j < i; j++)
                acc = acc - $signed(L[32*(4*i+j) +: 32]) * y[j];
            q = acc >>> 14;
`ifdef FWD_SAT_EN
            if (q > 67'sd2147483647) begin
                q = 67'sd2147483647; o = 1'b1;
            end else if (q < -67'sd2147483648) begin
                q = -67'sd2147483648; o = 1'b1;
            end
`endif
            y[i] = q[31:0];
            r[32*i +: 32] = y[i];
        end
        return r;
    endfunction

    // Build L from the six strictly-lower entries; diagonal/upper get junk.
    function automatic logic [511:0] mk_l(input logic [31:0] l10, l20, l21, l30, l31, l32);
        logic [511:0] m;
        for (int k = 0; k < 16; k++) m[32*k +: 32] = $urandom;
        m[32*4 +: 32]  = l10;
        m[32*8 +: 32]  = l20;
        m[32*9 +: 32]  = l21;
        m[32*12 +: 32] = l30;
        m[32*13 +: 32] = l31;
        m[32*14 +: 32] = l32;
        return m;
    endfunction

    // Run one solve; returns result, ovf, edges from accept to done, done count.
    task automatic run_solve(input logic [511:0] L, input logic [127:0] b, input bit glitch,
                             output logic [127:0] y, output logic o, output int lat,
                             output int ndone);
        @(negedge clk);
        ifc.L_in  = L;
        ifc.b_in  = b;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        chk("busy_after_accept", 128'(ifc.busy), 128'd1);
        lat = -1; ndone = 0; y = '0; o = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (ifc.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k; y = ifc.y_out; o = ifc.ovf;
                end
            end
            if (k == 1 && !glitch) begin
                ifc.L_in = {16{$urandom}};
                ifc.b_in = {4{$urandom}};
            end
            if (glitch && k == 3) begin
                ifc.start = 1'b1;
                ifc.b_in  = {4{$urandom}};
            end
            if (glitch && k == 4) ifc.start = 1'b0;
        end
        chk("busy_idle_after", 128'(ifc.busy), 128'd0);
        chk("y_stable_after_done", ifc.y_out, y);
    endtask

    task automatic do_case(input string tag, input logic [511:0] L, input logic [127:0] b,
                           input bit glitch, output logic [127:0] y);
        logic [127:0] ey;
        logic eo, o;
        int lat, nd;
        ey = ref_solve(L, b, eo);
        run_solve(L, b, glitch, y, o, lat, nd);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_ovf"}, 128'(o), 128'(eo));
        chk({tag, "_lat"}, 128'(lat), 128'd10);
        chk({tag, "_ndone"}, 128'(nd), 128'd1);
    endtask

    logic [511:0] L2;
    logic [127:0] b2, y, exp_pt;

    initial begin
        ifc.start = 1'b0;
        ifc.L_in  = '0;
        ifc.b_in  = '0;
        #12;
        chk("rst_y", ifc.y_out, 128'd0);
        chk("rst_busy", 128'(ifc.busy), 128'd0);
        chk("rst_done", 128'(ifc.done), 128'd0);
        chk("rst_ovf", 128'(ifc.ovf), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        exp_pt = {32'd98304, 32'd81920, 32'd114688, 32'd294912};

        // Identity: exact pass-through.
        do_case("ident", mk_l(0, 0, 0, 0, 0, 0), exp_pt, 1'b0, y);
        chk("ident_lit", y, exp_pt);

        // Full solve feeding backward.
        L2 = mk_l(32'd8192, 32'd4096, 32'd16384, 32'd0, 32'd8192, -32'sd16384);
        b2 = {32'd73728, 32'd270336, 32'd262144, 32'd294912};
        do_case("full", L2, b2, 1'b0, y);
        chk("full_lit", y, exp_pt);

        // Floor truncation.
        do_case("floor", mk_l(3, 0, 0, 0, 0, 0), 128'd1, 1'b0, y);
        chk("floor_lit", y, {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1});

        // Overflow of row 1.
        do_case("ovf", mk_l(-32'sd32768, 0, 0, 0, 0, 0), {96'd0, 32'h7FFF_FFFF}, 1'b0, y);
`ifdef FWD_SAT_EN
        chk("ovf_y1", 128'(y[63:32]), 128'h7FFF_FFFF);
        chk("ovf_flag", 128'(ifc.ovf), 128'd1);
`else
        chk("ovf_y1", 128'(y[63:32]), 128'hFFFF_FFFE);
        chk("ovf_flag", 128'(ifc.ovf), 128'd0);
`endif

        // Start while busy is ignored.
        do_case("busy_start", L2, b2, 1'b1, y);

        // Reset in MAC21 (4 edges after accept).
        @(negedge clk);
        ifc.L_in = L2; ifc.b_in = b2; ifc.start = 1'b1;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_y", ifc.y_out, 128'd0);
        chk("abort_busy", 128'(ifc.busy), 128'd0);
        begin
            int nd = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk);
                #1 if (ifc.done) nd++;
                if (k == 3) rst_n = 1'b1;
            end
            chk("abort_no_done", 128'(nd), 128'd0);
        end
        do_case("after_abort", L2, b2, 1'b0, y);
        chk("after_abort_lit", y, exp_pt);

        // Randomized: half full-range (exercises wrap/clamp), half moderate.
        for (int t = 0; t < 24; t++) begin
            logic [511:0] lr;
            logic [127:0] br;
            for (int k = 0; k < 16; k++) lr[32*k +: 32] = $urandom;
            for (int k = 0; k < 4; k++) br[32*k +: 32] = $urandom;
            if (t % 2) begin
                for (int k = 0; k < 16; k++)
                    lr[32*k +: 32] = 32'($signed($urandom_range(65535)) - 32768);
                for (int k = 0; k < 4; k++)
                    br[32*k +: 32] = 32'($signed($urandom_range(2097151)) - 1048576);
            end
            do_case("rand", lr, br, 1'b0, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/forward_sub.md
# forward_sub

Sequential 4×4 forward-substitution solver: it computes y from L·y = b, where L is a unit-lower-triangular matrix in Q14 fixed point. It sits directly upstream of `backward`, and its `y_out` connects straight to `backward.y_in`. The solver uses one multiply-subtract per cycle and a start/done handshake. It shares the `backward` matrix packing and Q14 scaling.

## Interface
- `N`, 4: matrix order; only 4 is supported.
- `W`, 32: signed element width.
- `FRAC`, 14: fractional bits; 16384 represents 1.0.
- `clk`  in  1: clock, rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: request to solve; sampled only in IDLE.
- `L_in`  in  N*N*W: row-major; element (r,c) occupies bits [W*(N*r+c)+W-1 : W*(N*r+c)]. Diagonal and upper entries are ignored; the diagonal is implicitly 1.0.
- `b_in`  in  N*W: element i occupies bits [W*i+W-1 : W*i], Q14.
- `y_out`  out  N*W: result in Q14, same packing as `b_in`.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `done`  out  1: one-cycle pulse; `y_out` is valid from this cycle onward.
- `ovf`  out  1: overflow flag; see Configuration.

## Operation
- FSM states: IDLE, MAC, STORE, DONE.
- **IDLE, `start`=1:** latch `L_in` and `b_in` into internal registers. Set i=0, j=0, acc = b_0 <<< FRAC, clear `ovf`, then go to STORE. Row 0 needs no MAC.
- **MAC:** acc ← acc − L[i][j]·y[j]; j++. If j == i−1, next state is STORE.
- **STORE:** y[i] ← trunc(acc >>> FRAC).
  - If i == N−1, go to DONE.
  - Otherwise i++, j=0, acc = b_{i+1} <<< FRAC, go to MAC.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- Arithmetic:
  - Each product is 2W signed.
  - acc is 2W+3 bits signed.
  - `>>>` is an arithmetic shift, i.e. floor toward −∞.
  - trunc keeps the low W bits unless FWD_SAT_EN is defined.
- `y_out` is driven from the y registers and is updated row by row during a solve. It is guaranteed valid and stable from `done` until the next accepted `start`.
- `start` outside IDLE is ignored, including during the DONE cycle. Holding `start` high re-triggers in the first IDLE cycle.
- Input changes after the accept edge have no effect on the current solve.

## Timing
- Reset values: `y_out`=0, `done`=0, `busy`=0, `ovf`=0, state IDLE, all internal registers 0.
- Latency: N(N+1)/2 = 10 edges. If `start` is sampled at edge E0, `done` is high in the cycle after E10.
- State sequence for N=4: STORE0, MAC10, STORE1, MAC20, MAC21, STORE2, MAC30, MAC31, MAC32, STORE3, DONE.
- `busy` rises the cycle after the accept edge and falls after the DONE cycle. Minimum start-to-start spacing is 12 cycles.
- Reset asserted mid-solve: state and outputs return to reset values immediately (asynchronous). No `done` is produced for the aborted solve.

## Configuration
- Macro: `FWD_SAT_EN`.
- **Defined:**
  - In STORE, a shifted acc outside [−2^(W−1), 2^(W−1)−1] is clamped to the nearest bound.
  - `ovf` is set sticky until the next accepted `start`.
- **Undefined:**
  - Plain two's-complement wrap to W bits.
  - `ovf` is tied 0.

## Structure
- Package `fwd_pkg` holds:
  - the N, W and FRAC defaults;
  - the state enum;
  - the accumulator width constant (2W+3);
  - the element-index function (r,c) → bit offset, shared with `backward`.
- One sub-module, `fwd_mac`: combinational signed acc − a·b with a 2W+3-bit result. The FSM registers its output.

## Test plan
- **Identity, exact pass-through.** L off-diagonal all 0; b=(294912,114688,81920,98304) → y_out=(294912,114688,81920,98304). `done` is exactly 10 edges after the accept edge.
- **Full solve, chained to backward.** L10=8192, L20=4096, L21=16384, L30=0, L31=8192, L32=−16384; b=(294912,262144,270336,73728) → y_out=(294912,114688,81920,98304). Feeding that y_out into `backward` gives x=(5,2,−4,3).
- **Floor truncation.** L10=3, others 0; b=(1,0,0,0) → y_out=(1,−1,0,0).
- **Overflow.** L10=−32768, others 0; b=(0x7FFFFFFF,0,0,0).
  - With FWD_SAT_EN: y1=0x7FFFFFFF, `ovf`=1.
  - Without it: y1=0xFFFFFFFE, `ovf`=0.
- **Start while busy.** Pulse `start` 3 cycles after accept with different b → ignored; result matches the first b, and exactly one `done` pulse.
- **Reset mid-solve.** Drive `rst` low during MAC21 → `done` never pulses, and `y_out`/`busy` are 0. After release, the scenario-2 solve is correct.
